// File: rtl/fir_burst_sched.sv
// Burst scheduler for one FIR run: kicks the engine, streams X from the X buffer through a
// 2-entry skid FIFO, caps samples in flight, and writes returned Y into the Y buffer.
module fir_burst_sched #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int LEN_W     = 16,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ADDR_W-1:0] cfg_x_base,
    input  logic [ADDR_W-1:0] cfg_y_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       status_code,
    output logic              fir_ap_start,
    input  logic              fir_ap_idle,
    input  logic              fir_ap_done,
    output logic              xbuf_re,
    output logic [ADDR_W-1:0] xbuf_addr,
    input  logic [DATA_W-1:0] xbuf_rdata,
    output logic              ss_tvalid,
    output logic [DATA_W-1:0] ss_tdata,
    output logic              ss_tlast,
    input  logic              ss_tready,
    input  logic              sm_tvalid,
    input  logic [DATA_W-1:0] sm_tdata,
    input  logic              sm_tlast,
    output logic              sm_tready,
    output logic              ybuf_we,
    output logic [ADDR_W-1:0] ybuf_addr,
    output logic [DATA_W-1:0] ybuf_wdata
);

    localparam int OUT_W = 9;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KICK = 3'd1,
        ST_RUN  = 3'd2,
        ST_WAIT = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t            state_r;
    logic [LEN_W-1:0]  len_r;
    logic [ADDR_W-1:0] x_base_r;
    logic [ADDR_W-1:0] y_base_r;
    logic [LEN_W-1:0]  sent_rd_r;
    logic [LEN_W-1:0]  sent_ss_r;
    logic [LEN_W-1:0]  recv_r;
    logic [OUT_W-1:0]  outstanding_r;
    logic [WD_W-1:0]   wd_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [15:0]       status_r;
    logic              ap_start_r;
    logic              sm_tready_r;

    logic [DATA_W-1:0] fifo_mem_r [2];
    logic              fifo_wr_r;
    logic              fifo_rd_r;
    logic [1:0]        fifo_cnt_r;
    logic              rd_inflight_r;

    logic x_hs_s;
    logic y_hs_s;
    logic xbuf_re_s;
    logic last_y_s;
    logic tlast_bad_s;
    logic wd_expire_s;
    logic abort_s;

    assign ss_tvalid   = (fifo_cnt_r != 2'd0);
    assign ss_tdata    = fifo_mem_r[fifo_rd_r];
    assign ss_tlast    = ss_tvalid && (sent_ss_r == (len_r - LEN_W'(1'b1)));
    assign x_hs_s      = ss_tvalid && ss_tready;
    assign y_hs_s      = sm_tvalid && sm_tready_r;
    // Reads stop once the skid FIFO plus the read in flight would overflow, or the burst window is full.
    assign xbuf_re_s   = (state_r == ST_RUN) && (sent_rd_r < len_r)
                         && (({1'b0, fifo_cnt_r} + {2'b00, rd_inflight_r}) < 3'd2)
                         && (outstanding_r < OUT_W'(BURST_LEN));
    assign last_y_s    = (recv_r == (len_r - LEN_W'(1'b1)));
    assign tlast_bad_s = y_hs_s && (sm_tlast != last_y_s);
    assign wd_expire_s = (wd_r == WD_W'(TIMEOUT - 1));
    assign abort_s     = ((state_r == ST_RUN) && tlast_bad_s)
                         || (((state_r == ST_RUN) || (state_r == ST_WAIT))
                             && !x_hs_s && !y_hs_s && wd_expire_s);

    assign xbuf_re      = xbuf_re_s;
    assign xbuf_addr    = x_base_r + ADDR_W'(sent_rd_r);
    assign ybuf_we      = y_hs_s;
    assign ybuf_addr    = y_base_r + ADDR_W'(recv_r);
    assign ybuf_wdata   = sm_tdata;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign status_code  = status_r;
    assign fir_ap_start = ap_start_r;
    assign sm_tready    = sm_tready_r;

    // Skid FIFO between the X buffer read port and the X stream; flushed on abort.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            fifo_wr_r     <= 1'b0;
            fifo_rd_r     <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            rd_inflight_r <= 1'b0;
        end else if (abort_s) begin
            fifo_wr_r     <= 1'b0;
            fifo_rd_r     <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            rd_inflight_r <= 1'b0;
        end else begin
            rd_inflight_r <= xbuf_re_s;
            if (rd_inflight_r) begin
                fifo_mem_r[fifo_wr_r] <= xbuf_rdata;
                fifo_wr_r             <= ~fifo_wr_r;
            end
            if (x_hs_s) begin
                fifo_rd_r <= ~fifo_rd_r;
            end
            case ({rd_inflight_r, x_hs_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Run sequencer: config latch, progress counters, watchdog and sticky status.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_r       <= ST_IDLE;
            len_r         <= '0;
            x_base_r      <= '0;
            y_base_r      <= '0;
            sent_rd_r     <= '0;
            sent_ss_r     <= '0;
            recv_r        <= '0;
            outstanding_r <= '0;
            wd_r          <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            status_r      <= 16'h0000;
            ap_start_r    <= 1'b0;
            sm_tready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_len == '0) begin
                            done_r   <= 1'b1;
                            err_r    <= 1'b0;
                            status_r <= 16'hAB51;
                        end else if (!fir_ap_idle) begin
                            done_r   <= 1'b0;
                            err_r    <= 1'b1;
                            status_r <= 16'hAB5E;
                        end else begin
                            len_r         <= cfg_len;
                            x_base_r      <= cfg_x_base;
                            y_base_r      <= cfg_y_base;
                            sent_rd_r     <= '0;
                            sent_ss_r     <= '0;
                            recv_r        <= '0;
                            outstanding_r <= '0;
                            wd_r          <= '0;
                            done_r        <= 1'b0;
                            err_r         <= 1'b0;
                            busy_r        <= 1'b1;
                            ap_start_r    <= 1'b1;
                            status_r      <= 16'hAB40;
                            state_r       <= ST_KICK;
                        end
                    end
                end
                ST_KICK: begin
                    ap_start_r  <= 1'b0;
                    sm_tready_r <= 1'b1;
                    wd_r        <= '0;
                    state_r     <= ST_RUN;
                end
                ST_RUN: begin
                    if (xbuf_re_s) begin
                        sent_rd_r <= sent_rd_r + LEN_W'(1'b1);
                    end
                    if (x_hs_s) begin
                        sent_ss_r <= sent_ss_r + LEN_W'(1'b1);
                    end
                    if (y_hs_s) begin
                        recv_r <= recv_r + LEN_W'(1'b1);
                    end
                    outstanding_r <= outstanding_r + OUT_W'(xbuf_re_s) - OUT_W'(y_hs_s);
                    if (tlast_bad_s) begin
                        busy_r      <= 1'b0;
                        err_r       <= 1'b1;
                        status_r    <= 16'hAB5E;
                        sm_tready_r <= 1'b0;
                        state_r     <= ST_ERR;
                    end else if (y_hs_s && last_y_s) begin
                        sm_tready_r <= 1'b0;
                        wd_r        <= '0;
                        state_r     <= ST_WAIT;
                    end else if (x_hs_s || y_hs_s) begin
                        wd_r <= '0;
                    end else if (wd_expire_s) begin
                        busy_r      <= 1'b0;
                        err_r       <= 1'b1;
                        status_r    <= 16'hAB5E;
                        sm_tready_r <= 1'b0;
                        state_r     <= ST_ERR;
                    end else begin
                        wd_r <= wd_r + WD_W'(1'b1);
                    end
                end
                ST_WAIT: begin
                    if (fir_ap_done) begin
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        status_r <= 16'hAB51;
                        state_r  <= ST_IDLE;
                    end else if (wd_expire_s) begin
                        busy_r   <= 1'b0;
                        err_r    <= 1'b1;
                        status_r <= 16'hAB5E;
                        state_r  <= ST_ERR;
                    end else begin
                        wd_r <= wd_r + WD_W'(1'b1);
                    end
                end
                ST_ERR: begin
                    sm_tready_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_burst_sched.sv
// Bench for fir_burst_sched: an echo-style FIR model (Y = ~X) plus a scoreboard of expected Y buffer writes.
module tb_fir_burst_sched;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 16;
    localparam int BL = 8;
    localparam int TO = 64;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic [AW-1:0] cfg_x_base = '0;
    logic [AW-1:0] cfg_y_base = '0;
    logic          busy, done, err;
    logic [15:0]   status_code;
    logic          fir_ap_start;
    logic          fir_ap_idle = 1'b1;
    logic          fir_ap_done = 1'b0;
    logic          xbuf_re;
    logic [AW-1:0] xbuf_addr;
    logic [DW-1:0] xbuf_rdata = '0;
    logic          ss_tvalid, ss_tlast;
    logic [DW-1:0] ss_tdata;
    logic          ss_tready = 1'b0;
    logic          sm_tvalid = 1'b0;
    logic [DW-1:0] sm_tdata = '0;
    logic          sm_tlast = 1'b0;
    logic          sm_tready;
    logic          ybuf_we;
    logic [AW-1:0] ybuf_addr;
    logic [DW-1:0] ybuf_wdata;

    fir_burst_sched #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .cfg_x_base(cfg_x_base), .cfg_y_base(cfg_y_base), .busy(busy), .done(done), .err(err),
        .status_code(status_code), .fir_ap_start(fir_ap_start), .fir_ap_idle(fir_ap_idle),
        .fir_ap_done(fir_ap_done), .xbuf_re(xbuf_re), .xbuf_addr(xbuf_addr), .xbuf_rdata(xbuf_rdata),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .ybuf_we(ybuf_we), .ybuf_addr(ybuf_addr), .ybuf_wdata(ybuf_wdata)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        int          len;
        int          x_base;
        int          y_base;
        int          rdy_pct;
        int          vld_pct;
        bit          hold8;
        int          bad_last;
        bit          drop_last;
        bit          no_y;
        bit          mid_start;
        bit          exp_done;
        bit          exp_err;
        logic [15:0] exp_status;
        int          exp_writes;
        bit          exp_peak8;
    } vec_t;

    vec_t          vecs [9];
    logic [DW-1:0] xmem [1024];
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int len, xb, yb, rdy, vld, input bit hold8, input int bad_last,
                                input bit drop_last, no_y, mid_start, exp_done, exp_err,
                                input logic [15:0] exp_status, input int exp_writes, input bit exp_peak8);
        vec_t v;
        v.len = len; v.x_base = xb; v.y_base = yb; v.rdy_pct = rdy; v.vld_pct = vld;
        v.hold8 = hold8; v.bad_last = bad_last; v.drop_last = drop_last; v.no_y = no_y;
        v.mid_start = mid_start; v.exp_done = exp_done; v.exp_err = exp_err;
        v.exp_status = exp_status; v.exp_writes = exp_writes; v.exp_peak8 = exp_peak8;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        logic [AW+DW-1:0] exp_q [$];
        logic [DW-1:0]    fir_q [$];
        logic [AW+DW-1:0] e;
        logic [DW-1:0]    prev_data;
        logic [AW-1:0]    re_addr;
        bit  re_pend, prev_stall, finished, sm_hs;
        int  xacc, yemit, writes, ap_starts, outst, peak, last_hs, err_cyc;
        string pfx;
        pfx = $sformatf("v%0d", id);
        for (int i = 0; i < v.len; i++) begin
            exp_q.push_back({AW'(v.y_base + i), ~xmem[(v.x_base + i) % 1024]});
        end
        re_pend = 1'b0; prev_stall = 1'b0; finished = 1'b0; prev_data = '0; re_addr = '0;
        xacc = 0; yemit = 0; writes = 0; ap_starts = 0; outst = 0; peak = 0; last_hs = -1; err_cyc = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge axis_clk);
            cfg_start  = (cyc == 0) || (v.mid_start && cyc == 6);
            cfg_len    = (cyc == 0) ? LW'(v.len) : LW'(3);
            cfg_x_base = (cyc == 0) ? AW'(v.x_base) : AW'(5);
            cfg_y_base = (cyc == 0) ? AW'(v.y_base) : AW'(7);
            ss_tready  = ($urandom_range(99) < v.rdy_pct);
            sm_tvalid  = (fir_q.size() > 0) && !v.no_y && (!v.hold8 || xacc >= ((v.len < 8) ? v.len : 8))
                         && ($urandom_range(99) < v.vld_pct);
            sm_tdata   = (fir_q.size() > 0) ? fir_q[0] : '0;
            if (v.drop_last && yemit == v.len - 1) sm_tlast = 1'b0;
            else if (yemit == v.bad_last)          sm_tlast = 1'b1;
            else                                   sm_tlast = (yemit == v.len - 1);
            fir_ap_done = (v.len != 0) && (yemit == v.len);
            #1;
            if (fir_ap_start) begin
                ap_starts++;
                check({pfx, "_kick_status"}, 32'(status_code), 32'hAB40);
            end
            if (prev_stall) begin
                check({pfx, "_ss_hold_valid"}, 32'(ss_tvalid), 32'd1);
                check({pfx, "_ss_hold_data"}, ss_tdata, prev_data);
            end
            prev_stall = ss_tvalid && !ss_tready;
            prev_data  = ss_tdata;
            if (xbuf_re) begin
                re_pend = 1'b1; re_addr = xbuf_addr; outst++;
            end
            sm_hs = sm_tvalid && sm_tready;
            if (sm_hs) begin
                void'(fir_q.pop_front()); yemit++; outst--; last_hs = cyc;
            end
            if (ss_tvalid && ss_tready) begin
                check({pfx, "_ss_tlast"}, 32'(ss_tlast), 32'(xacc == v.len - 1));
                fir_q.push_back(~ss_tdata); xacc++; last_hs = cyc;
            end
            if (ybuf_we) begin
                writes++;
                check({pfx, "_we_with_hs"}, 32'(sm_hs), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({pfx, "_y_addr"}, 32'(ybuf_addr), 32'(e[AW+DW-1:DW]));
                    check({pfx, "_y_data"}, ybuf_wdata, e[DW-1:0]);
                end else begin
                    check({pfx, "_y_extra"}, 32'(writes), 32'(v.len));
                end
            end
            if (outst > peak) peak = outst;
            if (err && err_cyc < 0) err_cyc = cyc;
            if (cyc >= 2 && !busy) begin
                finished = 1'b1;
                break;
            end
            @(posedge axis_clk);
            #1;
            if (re_pend) xbuf_rdata = xmem[re_addr];
            re_pend = 1'b0;
        end
        cfg_start = 1'b0; sm_tvalid = 1'b0; ss_tready = 1'b0;
        check({pfx, "_finished"}, 32'(finished), 32'd1);
        check({pfx, "_done"}, 32'(done), 32'(v.exp_done));
        check({pfx, "_err"}, 32'(err), 32'(v.exp_err));
        check({pfx, "_status"}, 32'(status_code), 32'(v.exp_status));
        check({pfx, "_writes"}, 32'(writes), 32'(v.exp_writes));
        check({pfx, "_ap_starts"}, 32'(ap_starts), 32'(v.len != 0));
        check({pfx, "_peak_le_burst"}, 32'(peak <= BL), 32'd1);
        if (v.exp_peak8) check({pfx, "_peak_eq_burst"}, 32'(peak), 32'(BL));
        if (v.no_y) check({pfx, "_wd_window"}, 32'((err_cyc - last_hs) >= TO && (err_cyc - last_hs) <= TO + 2), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) xmem[i] = $urandom;
        vecs[0] = mk(4,  'h000, 'h100, 100, 100, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAB51, 4,  1'b0);
        vecs[1] = mk(20, 'h010, 'h200, 100, 100, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAB51, 20, 1'b1);
        vecs[2] = mk(30, 'h050, 'h020, 70,  60,  1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAB51, 30, 1'b0);
        vecs[3] = mk(4,  'h3F0, 'h3FE, 100, 100, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAB51, 4,  1'b0);
        vecs[4] = mk(5,  'h040, 'h060, 100, 100, 1'b0, 2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAB5E, 3,  1'b0);
        vecs[5] = mk(0,  'h000, 'h000, 100, 100, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAB51, 0,  1'b0);
        vecs[6] = mk(12, 'h080, 'h090, 100, 100, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAB5E, 0,  1'b0);
        vecs[7] = mk(9,  'h3FC, 'h010, 80,  80,  1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hAB51, 9,  1'b0);
        vecs[8] = mk(6,  'h100, 'h140, 50,  40,  1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAB5E, 6,  1'b0);

        // Reset values
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_status", 32'(status_code), 32'h0);
        check("rst_ap_start", 32'(fir_ap_start), 32'd0);
        check("rst_xbuf_re", 32'(xbuf_re), 32'd0);
        check("rst_ss_tvalid", 32'(ss_tvalid), 32'd0);
        check("rst_sm_tready", 32'(sm_tready), 32'd0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;

        for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

        // Start refused while the FIR engine is busy
        repeat (2) @(negedge axis_clk);
        fir_ap_idle = 1'b0; cfg_start = 1'b1; cfg_len = LW'(4);
        @(negedge axis_clk);
        cfg_start = 1'b0;
        #1;
        check("notidle_err", 32'(err), 32'd1);
        check("notidle_busy", 32'(busy), 32'd0);
        check("notidle_status", 32'(status_code), 32'hAB5E);
        check("notidle_ap_start", 32'(fir_ap_start), 32'd0);
        fir_ap_idle = 1'b1;

        // Asynchronous reset in the middle of a run
        @(negedge axis_clk);
        cfg_start = 1'b1; cfg_len = LW'(20); cfg_x_base = '0; cfg_y_base = '0;
        ss_tready = 1'b1; sm_tvalid = 1'b0; fir_ap_done = 1'b0;
        @(negedge axis_clk);
        cfg_start = 1'b0;
        repeat (6) @(negedge axis_clk);
        #1;
        check("midrst_running", 32'(busy), 32'd1);
        #2;
        axis_rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_status", 32'(status_code), 32'h0);
        check("midrst_xbuf_re", 32'(xbuf_re), 32'd0);
        check("midrst_ss_tvalid", 32'(ss_tvalid), 32'd0);
        check("midrst_sm_tready", 32'(sm_tready), 32'd0);
        check("midrst_done_err", 32'({done, err}), 32'd0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        ss_tready = 1'b0;
        run_vec(vecs[0], 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
